// File: rtl/freq_divider.sv
// Programmable clock-enable divider: a DIVISOR-cycle square wave plus a one-cycle
// end-of-period tick, both registered and updated only while enable is high.
module freq_divider #(
    parameter int unsigned DIVISOR   = 100000000,
    parameter int unsigned CNT_WIDTH = 27
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    output logic divFreq,
    output logic divTick
);

    generate
        if (DIVISOR < 2 || 64'(DIVISOR) > (64'd1 << CNT_WIDTH)) begin : g_bad_params
            $error("freq_divider: DIVISOR must be in 2..2**CNT_WIDTH");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DIVISOR - 1);
    // High phase starts at ceil(DIVISOR/2), so an odd divisor gets the longer low phase.
    localparam logic [CNT_WIDTH-1:0] HALF = CNT_WIDTH'((DIVISOR + 1) / 2);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 r_div_freq;
    logic                 r_div_tick;

    always_comb begin
        w_cnt_next = r_cnt;
        if (enable) begin
            w_cnt_next = (r_cnt == LAST) ? '0 : r_cnt + ONE;
        end
    end

    // Outputs decode the next count so they line up with r_cnt in the same cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_div_freq <= 1'b0;
            r_div_tick <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_div_freq <= (w_cnt_next >= HALF);
            r_div_tick <= (w_cnt_next == LAST);
        end
    end

    assign divFreq = r_div_freq;
    assign divTick = r_div_tick;

endmodule

// File: tb/tb_freq_divider.sv
// Drives several divider instances from shared inputs and checks each against a
// modulo-counter model of the period, plus directed pattern checks.
module tb_freq_divider;

    localparam int NI = 5;
    localparam longint DIVS [NI] = '{4, 5, 2, 7, 100000000};

    logic clock;
    logic resetn;
    logic enable;
    logic [NI-1:0] w_freq;
    logic [NI-1:0] w_tick;

    int n_cmp;
    int n_err;
    longint m_pos [NI];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    genvar g;
    generate
        for (g = 0; g < NI - 1; g++) begin : g_dut
            freq_divider #(.DIVISOR(int'(DIVS[g])), .CNT_WIDTH(8)) u_dut (
                .clock  (clock),
                .resetn (resetn),
                .enable (enable),
                .divFreq(w_freq[g]),
                .divTick(w_tick[g])
            );
        end
    endgenerate

    freq_divider u_dut_default (
        .clock  (clock),
        .resetn (resetn),
        .enable (enable),
        .divFreq(w_freq[NI-1]),
        .divTick(w_tick[NI-1])
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        @(posedge clock);
        for (int k = 0; k < NI; k++) begin
            if (!resetn) m_pos[k] = 0;
            else if (enable) m_pos[k] = (m_pos[k] + 1) % DIVS[k];
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("freq[D=%0d pos=%0d]", DIVS[k], m_pos[k]), w_freq[k],
                  logic'(m_pos[k] >= (DIVS[k] + 1) / 2));
            check($sformatf("tick[D=%0d pos=%0d]", DIVS[k], m_pos[k]), w_tick[k],
                  logic'(m_pos[k] == DIVS[k] - 1));
        end
    endtask

    logic pat4 [4];
    logic pat5 [5];

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        resetn = 1'b0;
        enable = 1'b0;
        for (int k = 0; k < NI; k++) m_pos[k] = 0;
        pat4 = '{1'b0, 1'b0, 1'b1, 1'b1};
        pat5 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset, including one edge with enable high to show reset wins.
        step();
        enable = 1'b1;
        step();

        // Directed periods from reset: D=4, D=5 and D=2 fixed patterns.
        resetn = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            step();
            check("pat4_freq", w_freq[0], pat4[j % 4]);
            check("pat4_tick", w_tick[0], logic'(j % 4 == 3));
            check("pat5_freq", w_freq[1], pat5[j % 5]);
            check("pat5_tick", w_tick[1], logic'(j % 5 == 4));
            check("pat2_freq", w_freq[2], logic'(j % 2));
            check("pat2_tick_eq_freq", w_tick[2], w_freq[2]);
        end

        // Hold with enable low while the D=4 divider sits at position 2.
        for (int j = 0; j < 8 && m_pos[0] != 2; j++) step();
        enable = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            check("hold_freq", w_freq[0], 1'b1);
            check("hold_tick", w_tick[0], 1'b0);
        end
        enable = 1'b1;
        step();
        check("resume_tick", w_tick[0], 1'b1);

        // Freeze on the last count: tick must stay asserted.
        enable = 1'b0;
        step();
        check("frozen_tick", w_tick[0], 1'b1);
        enable = 1'b1;

        // Mid-period reset at position 3, then a full period from zero.
        for (int j = 0; j < 8 && m_pos[0] != 3; j++) step();
        resetn = 1'b0;
        step();
        check("rst_freq", w_freq[0], 1'b0);
        check("rst_tick", w_tick[0], 1'b0);
        resetn = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            step();
            check("post_rst_freq", w_freq[0], pat4[j % 4]);
        end

        // Random enable and occasional reset.
        for (int j = 0; j < 3000; j++) begin
            enable = ($urandom_range(0, 3) != 0);
            resetn = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/freq_divider.md
FREQ_DIVIDER -- requirements
Module: freq_divider

Interface
REQ-001 Parameter DIVISOR, default 100000000: division ratio; output period is DIVISOR clock cycles (100 MHz in gives a 1 Hz gate).
REQ-002 Parameter CNT_WIDTH, default 27: counter width; requires 2^CNT_WIDTH >= DIVISOR.
REQ-003 Port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-004 Port resetn, input, 1: reset, synchronous, active-low.
REQ-005 Port enable, input, 1: count enable; 1 advances the divider, 0 freezes it.
REQ-006 Port divFreq, output, 1: divided square wave, period DIVISOR cycles.
REQ-007 Port divTick, output, 1: one-cycle marker of the last cycle of each output period.

Function
REQ-008 Elaboration shall fail when DIVISOR < 2 or when DIVISOR > 2^CNT_WIDTH.
REQ-009 Internal counter cnt (CNT_WIDTH bits) shall hold a value in 0..DIVISOR-1 at all times.
REQ-010 On each rising edge with resetn=1 and enable=1, cnt shall become 0 if cnt == DIVISOR-1 (wrap-around), otherwise cnt+1.
REQ-011 On each rising edge with resetn=1 and enable=0, cnt, divFreq and divTick shall hold their values.
REQ-012 H = ceil(DIVISOR/2). divFreq shall be 1 exactly while cnt >= H and 0 while cnt < H.
  - Low phase: ceil(DIVISOR/2) cycles.
  - High phase: floor(DIVISOR/2) cycles.
  - Duty cycle is exactly 50% for even DIVISOR. For odd DIVISOR the low phase is one cycle longer.
REQ-013 divTick shall be 1 exactly while cnt == DIVISOR-1. It stays 1 if enable freezes cnt at DIVISOR-1.
REQ-014 divFreq and divTick shall be driven directly from flip-flops, computed from the next counter value, with no combinational path from any input to either output.
REQ-015 Latency: the outputs change in the same cycle that cnt takes the corresponding value. There is no additional pipeline delay.
REQ-016 Counter arithmetic is unsigned. No intermediate value shall exceed DIVISOR-1 or overflow CNT_WIDTH.

Reset
REQ-017 A rising edge with resetn=0 shall set cnt=0, divFreq=0 and divTick=0, regardless of enable.
REQ-018 Reset asserted mid-period shall abort the current period. Counting restarts from cnt=0 on the first edge with resetn=1, and the first output period after reset is a full period.
REQ-019 Reset has priority over enable in the same cycle.

Verification
REQ-020 DIVISOR=4, enable=1, release reset, then 12 edges -> divFreq per cycle 0,0,1,1 repeating (first value is the reset cycle); divTick=1 only on cycles where divFreq is in its second high cycle.
REQ-021 DIVISOR=5, enable=1 after reset -> divFreq 0,0,0,1,1 repeating; divTick=1 once every 5 cycles, coincident with the second 1.
REQ-022 DIVISOR=4, drop enable for 3 cycles while divFreq=1 (cnt=2) -> divFreq stays 1 and divTick stays 0 during the hold; the sequence resumes at cnt=3 with no skipped or repeated count.
REQ-023 DIVISOR=4, assert resetn=0 for 1 cycle while cnt=3 -> next cycle divFreq=0, divTick=0; the following pattern is 0,0,1,1 from cnt=0.
REQ-024 DIVISOR=2 -> divFreq toggles every cycle (0,1,0,1); divTick equals divFreq.
REQ-025 Default parameters, enable=1 -> period of divFreq equals 100000000 cycles, with exactly 50000000 high cycles per period.
